// File: rtl/route_fifo_1to2_16b.sv
// Routes 16-bit words by in_sel into two independent per-channel FIFOs of DEPTH entries; optional ROUTE_FIFO_STATS_EN adds per-channel push counters.
// Latency: a word accepted on a rising edge is at the channel head the following cycle (no bypass).
// Backpressure: in_ready follows only the selected channel's full flag; a pop in the same cycle does not reopen a full channel.

module route_fifo_chan #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [15:0]              wdata,
    input  logic                     pop_ready,
    output logic [15:0]              rdata,
    output logic                     valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop;

    assign valid = (count != '0);
    assign full  = (count == FULL_CNT);
    assign pop   = valid & pop_ready;
    // Head is forced to zero when empty so stale storage never leaks out.
    assign rdata = valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end
endmodule

module route_fifo_1to2_16b #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              in_data,
    input  logic                     in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [15:0]              out0_data,
    output logic                     out0_valid,
    input  logic                     out0_ready,
    output logic [$clog2(DEPTH):0]   out0_count,
    output logic [15:0]              out1_data,
    output logic                     out1_valid,
    input  logic                     out1_ready,
    output logic [$clog2(DEPTH):0]   out1_count
`ifdef ROUTE_FIFO_STATS_EN
    ,
    output logic [7:0]               stat0,
    output logic [7:0]               stat1
`endif
);
    logic full0;
    logic full1;
    logic push0;
    logic push1;

    assign in_ready = in_sel ? ~full1 : ~full0;
    assign push0    = in_valid & in_ready & ~in_sel;
    assign push1    = in_valid & in_ready &  in_sel;

    route_fifo_chan #(.DEPTH(DEPTH)) u_chan0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push0),
        .wdata     (in_data),
        .pop_ready (out0_ready),
        .rdata     (out0_data),
        .valid     (out0_valid),
        .full      (full0),
        .count     (out0_count)
    );

    route_fifo_chan #(.DEPTH(DEPTH)) u_chan1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push1),
        .wdata     (in_data),
        .pop_ready (out1_ready),
        .rdata     (out1_data),
        .valid     (out1_valid),
        .full      (full1),
        .count     (out1_count)
    );

`ifdef ROUTE_FIFO_STATS_EN
    // Free-running 8-bit counters; wrap naturally at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat0 <= 8'd0;
            stat1 <= 8'd0;
        end else begin
            if (push0)
                stat0 <= stat0 + 8'd1;
            if (push1)
                stat1 <= stat1 + 8'd1;
        end
    end
`endif
endmodule
